// File: rtl/mac_crc32_sd_output.sv
// rtl/mac_crc32_sd_output.sv - GMII RX CRC-32 accumulator plus registered srdy/drdy output stage
module mac_crc32_sd_output #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             crc_clear,
  input  logic             crc_valid,
  input  logic [7:0]       crc_data,
  output logic [31:0]      crc,
  input  logic             ic_srdy,
  output logic             ic_drdy,
  input  logic [WIDTH-1:0] ic_data,
  output logic             p_srdy,
  input  logic             p_drdy,
  output logic [WIDTH-1:0] p_data
);

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

  logic [31:0]      r_crc;
  logic             r_p_srdy;
  logic [WIDTH-1:0] r_p_data;
  logic [31:0]      w_crc_next;
  logic             w_load;

  // Reflected CRC, bits consumed LSB-first to match GMII byte order on the wire.
  function automatic logic [31:0] f_crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] v;
    logic        fb;
    v = c;
    for (int i = 0; i < 8; i++) begin
      fb = v[0] ^ d[i];
      v  = (v >> 1) ^ (fb ? CRC_POLY : 32'h0);
    end
    return v;
  endfunction

  assign w_crc_next = f_crc_byte(r_crc, crc_data);
  assign crc        = ~r_crc;

  // A held word that is leaving this edge frees the slot for the incoming one.
  assign ic_drdy = ~r_p_srdy | p_drdy;
  assign w_load  = ic_srdy & ic_drdy;
  assign p_srdy  = r_p_srdy;
  assign p_data  = r_p_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_crc    <= CRC_INIT;
      r_p_srdy <= 1'b0;
      r_p_data <= '0;
    end else begin
      if (crc_clear) begin
        r_crc <= CRC_INIT;
      end else if (crc_valid) begin
        r_crc <= w_crc_next;
      end

      if (w_load) begin
        r_p_srdy <= 1'b1;
        r_p_data <= ic_data;
      end else if (p_drdy) begin
        r_p_srdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_crc32_sd_output.sv
// tb/tb_mac_crc32_sd_output.sv - scoreboard bench for mac_crc32_sd_output
module tb_mac_crc32_sd_output;

  localparam int WIDTH = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic             crc_clear;
  logic             crc_valid;
  logic [7:0]       crc_data;
  logic [31:0]      crc;
  logic             ic_srdy;
  logic             ic_drdy;
  logic [WIDTH-1:0] ic_data;
  logic             p_srdy;
  logic             p_drdy;
  logic [WIDTH-1:0] p_data;

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q[$];
  bit rand_drdy = 1'b0;

  mac_crc32_sd_output #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .crc_clear (crc_clear),
    .crc_valid (crc_valid),
    .crc_data  (crc_data),
    .crc       (crc),
    .ic_srdy   (ic_srdy),
    .ic_drdy   (ic_drdy),
    .ic_data   (ic_data),
    .p_srdy    (p_srdy),
    .p_drdy    (p_drdy),
    .p_data    (p_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitor: every downstream transfer must match the oldest accepted word.
  always @(negedge clk) begin
    if (reset === 1'b1 && p_srdy === 1'b1 && p_drdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_unexpected actual=0x%03h required=none", p_data);
      end else begin
        check("out_data", 32'(p_data), 32'(exp_q.pop_front()));
      end
    end
  end

  always @(posedge clk) begin
    if (rand_drdy) begin
      #1 p_drdy = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [WIDTH-1:0] w);
    int n;
    ic_srdy = 1'b1;
    ic_data = w;
    n = 0;
    forever begin
      @(negedge clk);
      if (ic_drdy === 1'b1) break;
      n++;
      if (n > 200) begin
        checks++;
        failures++;
        $display("FAIL send_timeout actual=ic_drdy_low required=accept word=0x%03h", w);
        ic_srdy = 1'b0;
        return;
      end
    end
    @(posedge clk);
    exp_q.push_back(w);
    #1 ic_srdy = 1'b0;
  endtask

  task automatic crc_byte(input logic [7:0] d);
    crc_valid = 1'b1;
    crc_data  = d;
    @(posedge clk);
    #1 crc_valid = 1'b0;
  endtask

  task automatic crc_check_string(input int gap);
    for (int i = 0; i < 9; i++) begin
      crc_byte(8'h31 + 8'(i));
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset     = 1'b0;
    crc_clear = 1'b0;
    crc_valid = 1'b0;
    crc_data  = 8'h00;
    ic_srdy   = 1'b0;
    ic_data   = '0;
    p_drdy    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_p_srdy", 32'(p_srdy), 32'd0);
    check("rst_p_data", 32'(p_data), 32'd0);
    check("rst_crc", crc, 32'h0000_0000);
    check("rst_ic_drdy", 32'(ic_drdy), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;

    // CRC check value and residue, back-to-back
    crc_check_string(0);
    @(negedge clk);
    check("crc_check", crc, 32'hCBF4_3926);
    crc_byte(8'h26); crc_byte(8'h39); crc_byte(8'hF4); crc_byte(8'hCB);
    @(negedge clk);
    check("crc_residue", crc, 32'h2144_DF1C);

    // Same with idle gaps between bytes
    crc_clear = 1'b1;
    @(posedge clk);
    #1 crc_clear = 1'b0;
    crc_check_string(2);
    @(negedge clk);
    check("crc_check_gap", crc, 32'hCBF4_3926);
    crc_byte(8'h26); @(posedge clk); #1;
    crc_byte(8'h39); crc_byte(8'hF4); @(posedge clk); #1;
    crc_byte(8'hCB);
    @(negedge clk);
    check("crc_residue_gap", crc, 32'h2144_DF1C);

    // Clear beats valid
    crc_clear = 1'b1;
    crc_valid = 1'b1;
    crc_data  = 8'h55;
    @(posedge clk);
    #1 crc_clear = 1'b0;
    crc_valid = 1'b0;
    @(negedge clk);
    check("crc_clear_prio", crc, 32'h0000_0000);
    crc_check_string(0);
    @(negedge clk);
    check("crc_after_clear", crc, 32'hCBF4_3926);

    // Single transfer with backpressure
    @(posedge clk); #1;
    p_drdy = 1'b0;
    send(10'h1AB);
    @(negedge clk);
    check("bp_p_srdy", 32'(p_srdy), 32'd1);
    check("bp_p_data", 32'(p_data), 32'h1AB);
    check("bp_ic_drdy", 32'(ic_drdy), 32'd0);
    @(negedge clk);
    check("bp_hold_p_srdy", 32'(p_srdy), 32'd1);
    check("bp_hold_ic_drdy", 32'(ic_drdy), 32'd0);
    @(posedge clk);
    #1 p_drdy = 1'b1;
    @(negedge clk);
    check("bp_release_ic_drdy", 32'(ic_drdy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("bp_drained_p_srdy", 32'(p_srdy), 32'd0);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Streaming at full rate
    @(posedge clk); #1;
    for (int i = 1; i <= 16; i++) begin
      ic_srdy = 1'b1;
      ic_data = WIDTH'(i);
      @(negedge clk);
      check("stream_ic_drdy", 32'(ic_drdy), 32'd1);
      if (i > 1) check("stream_p_srdy", 32'(p_srdy), 32'd1);
      @(posedge clk);
      exp_q.push_back(WIDTH'(i));
      #1;
    end
    ic_srdy = 1'b0;
    @(negedge clk);
    check("stream_last_p_srdy", 32'(p_srdy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("stream_queue_empty", 32'(exp_q.size()), 32'd0);

    // Random backpressure over 1000 words
    @(posedge clk); #1;
    rand_drdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(WIDTH'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk);
    rand_drdy = 1'b0;
    #1 p_drdy = 1'b1;
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
    @(negedge clk);
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-operation
    @(posedge clk); #1;
    p_drdy = 1'b0;
    send(10'h2C3);
    crc_byte(8'h31);
    crc_byte(8'h32);
    @(negedge clk);
    check("mid_held_p_srdy", 32'(p_srdy), 32'd1);
    @(posedge clk); #1;
    reset     = 1'b0;
    ic_srdy   = 1'b1;
    ic_data   = 10'h155;
    crc_valid = 1'b1;
    crc_clear = 1'b1;
    @(posedge clk);
    exp_q.delete();
    #1 reset = 1'b1;
    ic_srdy   = 1'b0;
    crc_valid = 1'b0;
    crc_clear = 1'b0;
    @(negedge clk);
    check("mid_rst_p_srdy", 32'(p_srdy), 32'd0);
    check("mid_rst_p_data", 32'(p_data), 32'd0);
    check("mid_rst_crc", crc, 32'h0000_0000);
    check("mid_rst_ic_drdy", 32'(ic_drdy), 32'd1);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
